// File: rtl/assoc_cache.sv
// assoc_cache -- two-way set-associative, write-back, write-allocate cache
// sitting between the multi-cycle CPU datapath and line-wide main memory.
//
// Geometry is parametrised (WORD_SIZE, LINE_WORDS, NUM_SETS). Each set holds
// two ways of {valid, dirty, tag, line} plus one LRU bit that names the
// least-recently-used way. A four-state FSM (IDLE, COMPARE, WRITEBACK, FILL)
// sequences every request.
//
// Optional feature: define CACHE_STATS_EN to add the saturating hit_count /
// miss_count statistics ports (width STAT_W).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   readC, writeC       processor read / write request, held until readyC
//   address, data_in    processor word address {tag,index,offset}, write data
//   data_out, readyC    read data (valid with readyC), one-cycle completion
//   readM, writeM       memory line read / write request
//   addressM            line-aligned memory address (offset bits zero)
//   dataM_out           eviction line, word 0 in the LSBs
//   dataM_in, ackM      fill line and one-cycle memory completion pulse
//   hit_count,
//   miss_count          statistics (CACHE_STATS_EN only)
module assoc_cache #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 4,
  parameter int STAT_W     = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            readC,
  input  logic                            writeC,
  input  logic [WORD_SIZE-1:0]            address,
  input  logic [WORD_SIZE-1:0]            data_in,
  output logic [WORD_SIZE-1:0]            data_out,
  output logic                            readyC,
  output logic                            readM,
  output logic                            writeM,
  output logic [WORD_SIZE-1:0]            addressM,
  output logic [LINE_WORDS*WORD_SIZE-1:0] dataM_out,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] dataM_in,
  input  logic                            ackM
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]               hit_count,
  output logic [STAT_W-1:0]               miss_count
`endif
);

  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = WORD_SIZE - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL
  } state_t;

  // A line is stored packed so that word 0 lands in the LSBs, matching the
  // memory-side bus layout directly.
  typedef logic [LINE_WORDS-1:0][WORD_SIZE-1:0] line_t;

  state_t state_q, state_d;

  // Latched request.
  logic                 op_write_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 victim_q;

  // Per-set storage.
  logic [1:0]           valid_q [NUM_SETS];
  logic [1:0]           dirty_q [NUM_SETS];
  logic [NUM_SETS-1:0]  lru_q;
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][2];
  line_t                line_q  [NUM_SETS][2];

  // Request field decode.
  logic [OFFSET_W-1:0]  req_offset;
  logic [INDEX_W-1:0]   req_index;
  logic [TAG_W-1:0]     req_tag;

  assign req_offset = addr_q[OFFSET_W-1:0];
  assign req_index  = addr_q[OFFSET_W +: INDEX_W];
  assign req_tag    = addr_q[WORD_SIZE-1 -: TAG_W];

  // Lookup in the addressed set.
  logic [1:0] way_hit;
  logic       hit;
  logic       hit_way;
  logic       victim_way;

  always_comb begin
    way_hit[0] = valid_q[req_index][0] && (tag_q[req_index][0] == req_tag);
    way_hit[1] = valid_q[req_index][1] && (tag_q[req_index][1] == req_tag);
    hit        = |way_hit;
    hit_way    = way_hit[1];
    // Prefer an empty way (way 0 first); otherwise replace the LRU way.
    if (!valid_q[req_index][0]) begin
      victim_way = 1'b0;
    end else if (!valid_q[req_index][1]) begin
      victim_way = 1'b1;
    end else begin
      victim_way = lru_q[req_index];
    end
  end

  // Next state and Moore/Mealy outputs. All handshake outputs are decoded
  // from the state register so an asynchronous reset clears them at once.
  always_comb begin
    state_d   = state_q;
    readyC    = 1'b0;
    readM     = 1'b0;
    writeM    = 1'b0;
    addressM  = '0;
    dataM_out = '0;
    data_out  = '0;
    case (state_q)
      IDLE: begin
        if (writeC || readC) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          readyC  = 1'b1;
          state_d = IDLE;
          if (!op_write_q) begin
            data_out = line_q[req_index][hit_way][req_offset];
          end
        end else if (valid_q[req_index][victim_way] && dirty_q[req_index][victim_way]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: begin
        writeM    = 1'b1;
        addressM  = {tag_q[req_index][victim_q], req_index, {OFFSET_W{1'b0}}};
        dataM_out = line_q[req_index][victim_q];
        if (ackM) begin
          state_d = FILL;
        end
      end
      FILL: begin
        readM    = 1'b1;
        addressM = {req_tag, req_index, {OFFSET_W{1'b0}}};
        if (ackM) begin
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  // Set on accept and cleared on the first COMPARE, so a request that
  // misses and re-enters COMPARE after its fill is only counted once.
  logic first_pass_q;
`endif

  // Control state and per-set status bits (reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      victim_q   <= 1'b0;
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
      lru_q      <= '0;
`ifdef CACHE_STATS_EN
      first_pass_q <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (writeC || readC) begin
            op_write_q <= writeC;
            addr_q     <= address;
            wdata_q    <= data_in;
`ifdef CACHE_STATS_EN
            first_pass_q <= 1'b1;
`endif
          end
        end
        COMPARE: begin
          if (hit) begin
            lru_q[req_index] <= ~hit_way;
            if (op_write_q) begin
              dirty_q[req_index][hit_way] <= 1'b1;
            end
          end else begin
            victim_q <= victim_way;
          end
`ifdef CACHE_STATS_EN
          first_pass_q <= 1'b0;
          if (first_pass_q) begin
            if (hit) begin
              if (hit_count != '1) begin
                hit_count <= hit_count + STAT_W'(1);
              end
            end else if (miss_count != '1) begin
              miss_count <= miss_count + STAT_W'(1);
            end
          end
`endif
        end
        WRITEBACK: begin
          if (ackM) begin
            dirty_q[req_index][victim_q] <= 1'b0;
          end
        end
        FILL: begin
          if (ackM) begin
            valid_q[req_index][victim_q] <= 1'b1;
            dirty_q[req_index][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and line storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state_q == FILL && ackM) begin
      tag_q[req_index][victim_q]  <= req_tag;
      line_q[req_index][victim_q] <= dataM_in;
    end else if (state_q == COMPARE && hit && op_write_q) begin
      line_q[req_index][hit_way][req_offset] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
`timescale 1ns/1ps
module tb_assoc_cache;

  localparam int WS = 16;
  localparam int LW = 4;
  localparam int NS = 4;
`ifdef CACHE_STATS_EN
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;
`else
  localparam int SW = 16;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          readC = 1'b0;
  logic          writeC = 1'b0;
  logic [15:0]   address = '0;
  logic [15:0]   data_in = '0;
  logic [15:0]   data_out;
  logic          readyC;
  logic          readM;
  logic          writeM;
  logic [15:0]   addressM;
  logic [63:0]   dataM_out;
  logic [63:0]   dataM_in = '0;
  logic          ackM = 1'b0;
`ifdef CACHE_STATS_EN
  logic [SW-1:0] hit_count;
  logic [SW-1:0] miss_count;
`endif

  assoc_cache #(
    .WORD_SIZE (WS),
    .LINE_WORDS(LW),
    .NUM_SETS  (NS),
    .STAT_W    (SW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .readC     (readC),
    .writeC    (writeC),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .readyC    (readyC),
    .readM     (readM),
    .writeM    (writeM),
    .addressM  (addressM),
    .dataM_out (dataM_out),
    .dataM_in  (dataM_in),
    .ackM      (ackM)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Physical memory seen by the DUT, and the reference model's own copy.
  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];

  // Reference model: per set a recency list of at most two resident lines,
  // position 0 = least recently used.
  logic [11:0] m_tag   [4][2];
  logic        m_dirty [4][2];
  logic [63:0] m_line  [4][2];
  int          m_cnt   [4];
  int          m_hit;
  int          m_miss;

  typedef struct packed {
    logic        miss;
    logic        wb;
    logic [15:0] wb_addr;
    logic [63:0] wb_data;
    logic [15:0] fill_addr;
    logic [15:0] rdata;
  } exp_t;

  typedef struct packed {
    logic        done;
    logic        both;
    logic [15:0] rdata;
    logic [31:0] cyc;
    logic [31:0] mem_exp;
    logic [31:0] n_wb;
    logic [31:0] n_fill;
    logic [15:0] wb_addr;
    logic [15:0] fill_addr;
    logic [63:0] wb_data;
  } obs_t;

  task automatic clear_model();
    for (int s = 0; s < 4; s++) m_cnt[s] = 0;
    m_hit  = 0;
    m_miss = 0;
  endtask

  task automatic model_op(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output exp_t e);
    int s, off, pos;
    logic [11:0] t;
    logic [63:0] ln;
    logic [11:0] tt;
    logic        dd;
    s = int'(a[3:2]); off = int'(a[1:0]); t = a[15:4]; pos = -1; e = '0;
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
    if (pos < 0) begin
      e.miss = 1'b1;
      m_miss++;
      if (m_cnt[s] == 2) begin
        if (m_dirty[s][0]) begin
          e.wb      = 1'b1;
          e.wb_addr = {m_tag[s][0], a[3:2], 2'b00};
          e.wb_data = m_line[s][0];
          for (int k = 0; k < 4; k++) ref_mem[e.wb_addr + 16'(k)] = m_line[s][0][k*16 +: 16];
        end
        m_tag[s][0] = m_tag[s][1]; m_dirty[s][0] = m_dirty[s][1]; m_line[s][0] = m_line[s][1];
        m_cnt[s] = 1;
      end
      e.fill_addr = {t, a[3:2], 2'b00};
      for (int k = 0; k < 4; k++) ln[k*16 +: 16] = ref_mem[e.fill_addr + 16'(k)];
      m_tag[s][m_cnt[s]] = t; m_dirty[s][m_cnt[s]] = 1'b0; m_line[s][m_cnt[s]] = ln;
      pos = m_cnt[s];
      m_cnt[s]++;
    end else begin
      m_hit++;
    end
    if (pos == 0 && m_cnt[s] == 2) begin
      tt = m_tag[s][0]; dd = m_dirty[s][0]; ln = m_line[s][0];
      m_tag[s][0] = m_tag[s][1]; m_dirty[s][0] = m_dirty[s][1]; m_line[s][0] = m_line[s][1];
      m_tag[s][1] = tt; m_dirty[s][1] = dd; m_line[s][1] = ln;
      pos = 1;
    end
    if (wr) begin
      m_line[s][pos][off*16 +: 16] = d;
      m_dirty[s][pos] = 1'b1;
    end else begin
      e.rdata = m_line[s][pos][off*16 +: 16];
    end
  endtask

  // Drives one processor request and plays the memory side with random ack
  // latency; returns what was observed on the DUT pins.
  task automatic run_op(input logic wr, input logic rd, input logic [15:0] a,
                        input logic [15:0] d, output obs_t o);
    int  wait_n;
    bit  in_txn;
    o = '0;
    @(negedge clk);
    writeC = wr; readC = rd; address = a; data_in = d;
    o.cyc = 1; in_txn = 0; wait_n = 0;
    while (!o.done && o.cyc < 100) begin
      @(posedge clk); #1;
      o.cyc = o.cyc + 1;
      if (ackM) begin ackM = 1'b0; in_txn = 0; end
      if (readM && writeM) o.both = 1'b1;
      if (readyC) begin
        o.done  = 1'b1;
        o.rdata = data_out;
      end else if (readM || writeM) begin
        if (!in_txn) begin
          in_txn = 1;
          wait_n = int'($urandom_range(0, 3));
          o.mem_exp = o.mem_exp + 32'(wait_n + 1);
          if (writeM) begin
            o.n_wb = o.n_wb + 1; o.wb_addr = addressM; o.wb_data = dataM_out;
          end else begin
            o.n_fill = o.n_fill + 1; o.fill_addr = addressM;
          end
        end
        if (wait_n == 0) begin
          ackM = 1'b1;
          if (writeM) begin
            for (int k = 0; k < 4; k++) mem[addressM + 16'(k)] = dataM_out[k*16 +: 16];
            dataM_in = {$urandom, $urandom};
          end else begin
            for (int k = 0; k < 4; k++) dataM_in[k*16 +: 16] = mem[addressM + 16'(k)];
          end
        end else begin
          wait_n--;
        end
      end
    end
    @(negedge clk);
    readC = 1'b0; writeC = 1'b0; ackM = 1'b0;
  endtask

  task automatic reset_dut();
    readC = 1'b0; writeC = 1'b0; ackM = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    readC = 1'b0; writeC = 1'b0; ackM = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({readyC, readM, writeM} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000", {readyC, readM, writeM});
    end
    checks++;
    if ({addressM, dataM_out, data_out} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data addressM=%h dataM_out=%h data_out=%h want all 0",
               addressM, dataM_out, data_out);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if ({hit_count, miss_count} !== '0) begin
      failures++;
      $display("FAIL reset_stats hit=%0d miss=%0d want 0 0", hit_count, miss_count);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic test_fill_then_hit();
    obs_t o; exp_t e;
    for (int k = 0; k < 4; k++) begin
      mem[16'h0010 + 16'(k)]     = 16'h1111 * 16'(k + 1);
      ref_mem[16'h0010 + 16'(k)] = 16'h1111 * 16'(k + 1);
    end
    model_op(1'b0, 16'h0010, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0010, 16'h0, o);
    checks++;
    if (o.done !== 1'b1 || o.n_fill !== 32'd1 || o.fill_addr !== 16'h0010) begin
      failures++;
      $display("FAIL first_fill done=%b fills=%0d addr=%h want 1 1 0010", o.done, o.n_fill, o.fill_addr);
    end
    checks++;
    if (o.rdata !== 16'h1111) begin
      failures++;
      $display("FAIL first_rdata got=%h want=1111", o.rdata);
    end
    checks++;
    if (o.cyc !== 32'(3) + o.mem_exp) begin
      failures++;
      $display("FAIL miss_latency got=%0d want=%0d", o.cyc, 3 + o.mem_exp);
    end
    model_op(1'b0, 16'h0011, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0011, 16'h0, o);
    checks++;
    if (o.rdata !== 16'h2222 || o.n_fill !== 32'd0) begin
      failures++;
      $display("FAIL hit_rdata got=%h fills=%0d want 2222 0", o.rdata, o.n_fill);
    end
    checks++;
    if (o.cyc !== 32'd2) begin
      failures++;
      $display("FAIL hit_latency got=%0d want=2", o.cyc);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== SW'(1) || miss_count !== SW'(1)) begin
      failures++;
      $display("FAIL stats_first hit=%0d miss=%0d want 1 1", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_lru();
    logic [15:0] addrs [5];
    int          fills [5];
    obs_t o; exp_t e;
    addrs = '{16'h0010, 16'h0110, 16'h0010, 16'h0210, 16'h0010};
    fills = '{0, 1, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      model_op(1'b0, addrs[i], 16'h0, e);
      run_op(1'b0, 1'b1, addrs[i], 16'h0, o);
      checks++;
      if (o.n_fill !== 32'(fills[i]) || o.n_wb !== 32'd0 || o.rdata !== e.rdata) begin
        failures++;
        $display("FAIL lru_step%0d addr=%h fills=%0d wbs=%0d rdata=%h want %0d 0 %h",
                 i, addrs[i], o.n_fill, o.n_wb, o.rdata, fills[i], e.rdata);
      end
    end
    checks++;
    if (o.rdata !== 16'h1111) begin
      failures++;
      $display("FAIL lru_survivor got=%h want=1111", o.rdata);
    end
  endtask

  task automatic test_writeback();
    obs_t o; exp_t e;
    reset_dut();
    model_op(1'b1, 16'h0012, 16'hBEEF, e);
    run_op(1'b1, 1'b0, 16'h0012, 16'hBEEF, o);
    checks++;
    if (o.n_fill !== 32'd1 || o.fill_addr !== 16'h0010) begin
      failures++;
      $display("FAIL wmiss_fill fills=%0d addr=%h want 1 0010", o.n_fill, o.fill_addr);
    end
    model_op(1'b0, 16'h0112, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0112, 16'h0, o);
    model_op(1'b0, 16'h0212, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0212, 16'h0, o);
    checks++;
    if (o.n_wb !== 32'd1 || o.wb_addr !== 16'h0010 || o.wb_data[47:32] !== 16'hBEEF) begin
      failures++;
      $display("FAIL evict wbs=%0d addr=%h word2=%h want 1 0010 BEEF", o.n_wb, o.wb_addr, o.wb_data[47:32]);
    end
    checks++;
    if (o.wb_data !== e.wb_data || o.fill_addr !== 16'h0210) begin
      failures++;
      $display("FAIL evict_line got=%h fill=%h want %h 0210", o.wb_data, o.fill_addr, e.wb_data);
    end
    checks++;
    if (o.cyc !== 32'(3) + o.mem_exp || o.both !== 1'b0) begin
      failures++;
      $display("FAIL dirty_latency got=%0d both=%b want %0d 0", o.cyc, o.both, 3 + o.mem_exp);
    end
    model_op(1'b0, 16'h0012, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0012, 16'h0, o);
    checks++;
    if (o.n_fill !== 32'd1 || o.rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL refetch fills=%0d rdata=%h want 1 BEEF", o.n_fill, o.rdata);
    end
  endtask

  task automatic test_both_req();
    obs_t o; exp_t e;
    model_op(1'b1, 16'h0020, 16'h00AA, e);
    run_op(1'b1, 1'b1, 16'h0020, 16'h00AA, o);
    model_op(1'b0, 16'h0020, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0020, 16'h0, o);
    checks++;
    if (o.rdata !== 16'h00AA) begin
      failures++;
      $display("FAIL both_req got=%h want=00AA", o.rdata);
    end
  endtask

  task automatic test_stray_ack();
    obs_t o; exp_t e;
    @(negedge clk);
    ackM = 1'b1;
    dataM_in = {$urandom, $urandom};
    @(posedge clk); #1;
    checks++;
    if ({readyC, readM, writeM} !== 3'b000) begin
      failures++;
      $display("FAIL stray_ack got=%b want=000", {readyC, readM, writeM});
    end
    @(negedge clk);
    ackM = 1'b0;
    model_op(1'b0, 16'h0020, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0020, 16'h0, o);
    checks++;
    if (o.rdata !== 16'h00AA || o.n_fill !== 32'd0) begin
      failures++;
      $display("FAIL after_stray rdata=%h fills=%0d want 00AA 0", o.rdata, o.n_fill);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    logic [2:0]  rdy;
    logic [15:0] dat [3];
    model_op(1'b0, 16'h0020, 16'h0, e1);
    model_op(1'b0, 16'h0020, 16'h0, e2);
    @(negedge clk);
    readC = 1'b1; writeC = 1'b0; address = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rdy[i] = readyC;
      dat[i] = data_out;
    end
    @(negedge clk);
    readC = 1'b0;
    checks++;
    if (rdy !== 3'b101) begin
      failures++;
      $display("FAIL held_req readyC seq=%b want=101", rdy);
    end
    checks++;
    if (dat[0] !== e1.rdata || dat[2] !== e2.rdata) begin
      failures++;
      $display("FAIL held_rdata got=%h,%h want=%h,%h", dat[0], dat[2], e1.rdata, e2.rdata);
    end
  endtask

  task automatic test_reset_mid_fill();
    obs_t o; exp_t e;
    bit seen;
    reset_dut();
    model_op(1'b0, 16'h0040, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0040, 16'h0, o);
    @(negedge clk);
    readC = 1'b1; address = 16'h0050;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (readM) seen = 1;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL fill_start readM never seen within 10 cycles");
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({readM, writeM} !== 2'b00 || addressM !== 16'h0) begin
      failures++;
      $display("FAIL abort readM=%b writeM=%b addressM=%h want 0 0 0000", readM, writeM, addressM);
    end
    readC = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    model_op(1'b0, 16'h0040, 16'h0, e);
    run_op(1'b0, 1'b1, 16'h0040, 16'h0, o);
    checks++;
    if (o.n_fill !== 32'd1 || o.rdata !== e.rdata) begin
      failures++;
      $display("FAIL post_reset_miss fills=%0d rdata=%h want 1 %h", o.n_fill, o.rdata, e.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [15:0] a, d;
    logic wr, rd;
    int sel;
    for (int n = 0; n < 250; n++) begin
      a   = {12'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      d   = 16'($urandom);
      sel = int'($urandom_range(0, 2));
      wr  = (sel != 0);
      rd  = (sel != 1);
      model_op(wr, a, d, e);
      run_op(wr, rd, a, d, o);
      checks++;
      if (o.done !== 1'b1 || o.both !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_handshake done=%b both=%b want 1 0", n, o.done, o.both);
      end
      checks++;
      if (o.n_fill !== 32'(e.miss) || o.n_wb !== 32'(e.wb)) begin
        failures++;
        $display("FAIL rnd%0d_mem addr=%h fills=%0d wbs=%0d want %0d %0d", n, a, o.n_fill, o.n_wb, e.miss, e.wb);
      end
      if (e.wb) begin
        checks++;
        if (o.wb_addr !== e.wb_addr || o.wb_data !== e.wb_data) begin
          failures++;
          $display("FAIL rnd%0d_wb addr=%h data=%h want %h %h", n, o.wb_addr, o.wb_data, e.wb_addr, e.wb_data);
        end
      end
      if (e.miss) begin
        checks++;
        if (o.fill_addr !== e.fill_addr) begin
          failures++;
          $display("FAIL rnd%0d_fill_addr got=%h want=%h", n, o.fill_addr, e.fill_addr);
        end
      end
      if (!wr) begin
        checks++;
        if (o.rdata !== e.rdata) begin
          failures++;
          $display("FAIL rnd%0d_rdata addr=%h got=%h want=%h", n, a, o.rdata, e.rdata);
        end
      end
      checks++;
      if (o.cyc !== 32'(2 + int'(e.miss)) + o.mem_exp) begin
        failures++;
        $display("FAIL rnd%0d_latency got=%0d want=%0d", n, o.cyc, 2 + int'(e.miss) + o.mem_exp);
      end
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== SW'(m_hit > SMAX ? SMAX : m_hit) ||
        miss_count !== SW'(m_miss > SMAX ? SMAX : m_miss)) begin
      failures++;
      $display("FAIL stats_saturate hit=%0d miss=%0d want %0d %0d", hit_count, miss_count,
               (m_hit > SMAX ? SMAX : m_hit), (m_miss > SMAX ? SMAX : m_miss));
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    clear_model();
    #3;
    test_reset();
    test_fill_then_hit();
    test_lru();
    test_writeback();
    test_both_req();
    test_stray_ack();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
